// File: rtl/eb_downsize_if.sv
// Handshake bundle for eb_downsize: one wide word stream in (t_0_*), narrow beats out (i_0_*).
// The slave modport is the converter's view; master is the surrounding environment's view.
interface eb_downsize_if #(
  parameter int WIDTH = 8,
  parameter int RATIO = 4
) ();
  logic [WIDTH*RATIO-1:0] t_0_data;
  logic                   t_0_valid;
  logic                   t_0_ready;
  logic [WIDTH-1:0]       i_0_data;
  logic                   i_0_last;
  logic                   i_0_valid;
  logic                   i_0_ready;

  modport slave (
    input  t_0_data,
    input  t_0_valid,
    output t_0_ready,
    output i_0_data,
    output i_0_last,
    output i_0_valid,
    input  i_0_ready
  );

  modport master (
    output t_0_data,
    output t_0_valid,
    input  t_0_ready,
    input  i_0_data,
    input  i_0_last,
    input  i_0_valid,
    output i_0_ready
  );
endinterface

// File: rtl/eb_downsize.sv
// Elastic width-down converter: holds one wide word and emits it as RATIO narrow beats,
// reloading on the last beat's handshake so consecutive words stream without bubbles.
module eb_downsize #(
  parameter int WIDTH     = 8,
  parameter int RATIO     = 4,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic         clk,
  input  logic         reset,
  eb_downsize_if.slave bus
);

  localparam int               CNT_W    = (RATIO > 1) ? $clog2(RATIO) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RATIO - 1);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_SEND  = 1'b1
  } state_t;

  state_t                      r_state;
  state_t                      w_state_nxt;
  logic [CNT_W-1:0]            r_cnt;
  logic [CNT_W-1:0]            w_cnt_nxt;
  logic [WIDTH*RATIO-1:0]      r_hold;
  logic                        w_load;
  logic                        w_last;
  logic                        w_t_ready;
  logic                        w_t_fire;
  logic                        w_i_fire;
  logic [CNT_W-1:0]            w_sel;
  logic [RATIO-1:0][WIDTH-1:0] w_beats;

  // Handshake terms; upstream ready looks only at state and downstream ready, never at t_0_valid.
  always_comb begin
    w_last    = (r_state == ST_SEND) && (r_cnt == LAST_CNT);
    w_t_ready = (r_state == ST_EMPTY) || (w_last && bus.i_0_ready);
    w_t_fire  = bus.t_0_valid && w_t_ready;
    w_i_fire  = (r_state == ST_SEND) && bus.i_0_ready;
  end

  // Next-state, beat counter and hold-load decision.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_load      = 1'b0;
    case (r_state)
      ST_EMPTY: begin
        if (w_t_fire) begin
          w_state_nxt = ST_SEND;
          w_cnt_nxt   = '0;
          w_load      = 1'b1;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_SEND: begin
        if (w_i_fire && w_last) begin
          w_cnt_nxt = '0;
          if (w_t_fire) begin
            w_load      = 1'b1;
            w_state_nxt = ST_SEND;
          end else begin
            w_state_nxt = ST_EMPTY;
          end
        end else if (w_i_fire) begin
          w_cnt_nxt = r_cnt + CNT_W'(1'b1);
        end else begin
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // State registers; hold only captures on an accepted word so idle-bus data never leaks in.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_EMPTY;
      r_cnt   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_load) begin
        r_hold <= bus.t_0_data;
      end else begin
        r_hold <= r_hold;
      end
    end
  end

  // Beat selection: the counter walks the slices upward or downward depending on beat order.
  always_comb begin
    w_beats = r_hold;
    if (MSB_FIRST) begin
      w_sel = LAST_CNT - r_cnt;
    end else begin
      w_sel = r_cnt;
    end
  end

  assign bus.t_0_ready = w_t_ready;
  assign bus.i_0_valid = (r_state == ST_SEND);
  assign bus.i_0_last  = w_last;
  assign bus.i_0_data  = w_beats[w_sel];

endmodule

// File: tb/tb_eb_downsize.sv
// Bench for eb_downsize: vector table on RATIO=4 (both beat orders), reset-mid-word sequence,
// and randomized RATIO=3 / RATIO=1 runs against a word-to-beat scoreboard.
module tb_eb_downsize;

  localparam int NV = 35;
  localparam int NW = 1000;

  logic clk;
  logic reset;
  int   n_tests;
  int   n_fail;
  bit   run_rand;
  int   pops_c;
  int   pops_d;
  logic [8:0] sb_c[$];
  logic [8:0] sb_d[$];

  eb_downsize_if #(.WIDTH(8), .RATIO(4)) if_a ();
  eb_downsize_if #(.WIDTH(8), .RATIO(4)) if_b ();
  eb_downsize_if #(.WIDTH(8), .RATIO(3)) if_c ();
  eb_downsize_if #(.WIDTH(8), .RATIO(1)) if_d ();

  eb_downsize #(.WIDTH(8), .RATIO(4), .MSB_FIRST(1'b0)) u_a (.clk(clk), .reset(reset), .bus(if_a.slave));
  eb_downsize #(.WIDTH(8), .RATIO(4), .MSB_FIRST(1'b1)) u_b (.clk(clk), .reset(reset), .bus(if_b.slave));
  eb_downsize #(.WIDTH(8), .RATIO(3), .MSB_FIRST(1'b0)) u_c (.clk(clk), .reset(reset), .bus(if_c.slave));
  eb_downsize #(.WIDTH(8), .RATIO(1), .MSB_FIRST(1'b0)) u_d (.clk(clk), .reset(reset), .bus(if_d.slave));

  assign if_b.t_0_data  = if_a.t_0_data;
  assign if_b.t_0_valid = if_a.t_0_valid;
  assign if_b.i_0_ready = if_a.i_0_ready;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        tv;
    logic [31:0] td;
    logic        ir;
    logic        ev;
    logic [7:0]  eda;
    logic [7:0]  edb;
    logic        el;
    logic        etr;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s: got an unexpected event, required none", name);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_a_valid"}, 32'(if_a.i_0_valid), 32'd0);
    check({tag, "_a_last"},  32'(if_a.i_0_last),  32'd0);
    check({tag, "_a_data"},  32'(if_a.i_0_data),  32'd0);
    check({tag, "_a_tready"}, 32'(if_a.t_0_ready), 32'd1);
    check({tag, "_b_valid"}, 32'(if_b.i_0_valid), 32'd0);
    check({tag, "_b_data"},  32'(if_b.i_0_data),  32'd0);
    check({tag, "_b_tready"}, 32'(if_b.t_0_ready), 32'd1);
    check({tag, "_c_valid"}, 32'(if_c.i_0_valid), 32'd0);
    check({tag, "_c_data"},  32'(if_c.i_0_data),  32'd0);
    check({tag, "_c_tready"}, 32'(if_c.t_0_ready), 32'd1);
    check({tag, "_d_valid"}, 32'(if_d.i_0_valid), 32'd0);
    check({tag, "_d_last"},  32'(if_d.i_0_last),  32'd0);
    check({tag, "_d_tready"}, 32'(if_d.t_0_ready), 32'd1);
  endtask

  // Scoreboard: beats leaving on this cycle's handshake are popped before new words are expanded.
  always @(negedge clk) begin
    if (run_rand) begin
      if (if_c.i_0_valid && if_c.i_0_ready) begin
        if (sb_c.size() == 0) begin
          fail_now("c_extra_beat");
        end else begin
          check("c_beat", 32'({if_c.i_0_last, if_c.i_0_data}), 32'(sb_c.pop_front()));
          pops_c++;
        end
      end
      if (if_c.t_0_valid && if_c.t_0_ready) begin
        for (int k = 0; k < 3; k++) begin
          sb_c.push_back({(k == 2), 8'(if_c.t_0_data >> (8 * k))});
        end
      end
      check("c_tready_rule", 32'(if_c.t_0_ready),
            32'(!if_c.i_0_valid || (if_c.i_0_last && if_c.i_0_ready)));

      if (if_d.i_0_valid && if_d.i_0_ready) begin
        if (sb_d.size() == 0) begin
          fail_now("d_extra_beat");
        end else begin
          check("d_beat", 32'({if_d.i_0_last, if_d.i_0_data}), 32'(sb_d.pop_front()));
          pops_d++;
        end
      end
      if (if_d.t_0_valid && if_d.t_0_ready) begin
        sb_d.push_back({1'b1, if_d.t_0_data});
      end
      check("d_last_rule", 32'(if_d.i_0_last), 32'(if_d.i_0_valid));
      check("d_tready_rule", 32'(if_d.t_0_ready), 32'(!if_d.i_0_valid || if_d.i_0_ready));
    end
  end

  initial begin
    logic [8:0]  qa[$];
    logic [8:0]  qb[$];
    logic [31:0] rc;
    logic [31:0] rd;
    logic [8:0]  ea;
    logic [8:0]  eb;
    logic        took_c;
    logic        took_d;
    int          sent_c;
    int          sent_d;
    int          cyc;

    n_tests  = 0;
    n_fail   = 0;
    run_rand = 1'b0;
    pops_c   = 0;
    pops_d   = 0;
    reset    = 1'b1;
    if_a.t_0_valid = 1'b0; if_a.t_0_data = 32'd0; if_a.i_0_ready = 1'b0;
    if_c.t_0_valid = 1'b0; if_c.t_0_data = 24'd0; if_c.i_0_ready = 1'b0;
    if_d.t_0_valid = 1'b0; if_d.t_0_data = 8'd0;  if_d.i_0_ready = 1'b0;

    //            tv    td            ir    ev    eda    edb    el    etr
    vecs[0]  = '{1'b1, 32'hDDCCBBAA, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[1]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'hAA, 8'hDD, 1'b0, 1'b0};
    vecs[2]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'hBB, 8'hCC, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'hCC, 8'hBB, 1'b0, 1'b0};
    vecs[4]  = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'hDD, 8'hAA, 1'b1, 1'b1};
    vecs[5]  = '{1'b0, 32'h00000000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[6]  = '{1'b1, 32'h03020100, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[7]  = '{1'b1, 32'h07060504, 1'b1, 1'b1, 8'h00, 8'h03, 1'b0, 1'b0};
    vecs[8]  = '{1'b1, 32'h07060504, 1'b1, 1'b1, 8'h01, 8'h02, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 32'h07060504, 1'b1, 1'b1, 8'h02, 8'h01, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 32'h07060504, 1'b1, 1'b1, 8'h03, 8'h00, 1'b1, 1'b1};
    vecs[11] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h04, 8'h07, 1'b0, 1'b0};
    vecs[12] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h05, 8'h06, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h06, 8'h05, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h07, 8'h04, 1'b1, 1'b1};
    vecs[15] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[16] = '{1'b1, 32'h13121110, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[17] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h10, 8'h13, 1'b0, 1'b0};
    vecs[18] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 8'h11, 8'h12, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 8'h11, 8'h12, 1'b0, 1'b0};
    vecs[20] = '{1'b0, 32'h00000000, 1'b0, 1'b1, 8'h11, 8'h12, 1'b0, 1'b0};
    vecs[21] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h11, 8'h12, 1'b0, 1'b0};
    vecs[22] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h12, 8'h11, 1'b0, 1'b0};
    vecs[23] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h13, 8'h10, 1'b1, 1'b1};
    vecs[24] = '{1'b1, 32'h23222120, 1'b0, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};
    vecs[25] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h20, 8'h23, 1'b0, 1'b0};
    vecs[26] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h21, 8'h22, 1'b0, 1'b0};
    vecs[27] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h22, 8'h21, 1'b0, 1'b0};
    vecs[28] = '{1'b1, 32'h33323130, 1'b0, 1'b1, 8'h23, 8'h20, 1'b1, 1'b0};
    vecs[29] = '{1'b1, 32'h33323130, 1'b1, 1'b1, 8'h23, 8'h20, 1'b1, 1'b1};
    vecs[30] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h30, 8'h33, 1'b0, 1'b0};
    vecs[31] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h31, 8'h32, 1'b0, 1'b0};
    vecs[32] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h32, 8'h31, 1'b0, 1'b0};
    vecs[33] = '{1'b0, 32'h00000000, 1'b1, 1'b1, 8'h33, 8'h30, 1'b1, 1'b1};
    vecs[34] = '{1'b0, 32'h00000000, 1'b1, 1'b0, 8'h00, 8'h00, 1'b0, 1'b1};

    #2;
    check_idle("rst");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #3;
      check_idle("post_rst");
    end

    for (int i = 0; i < NV; i++) begin
      @(posedge clk);
      #1;
      if_a.t_0_valid = vecs[i].tv;
      if_a.t_0_data  = vecs[i].td;
      if_a.i_0_ready = vecs[i].ir;
      #3;
      check($sformatf("v%0d_a_valid", i),  32'(if_a.i_0_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d_b_valid", i),  32'(if_b.i_0_valid), 32'(vecs[i].ev));
      check($sformatf("v%0d_a_last", i),   32'(if_a.i_0_last),  32'(vecs[i].el));
      check($sformatf("v%0d_b_last", i),   32'(if_b.i_0_last),  32'(vecs[i].el));
      check($sformatf("v%0d_a_tready", i), 32'(if_a.t_0_ready), 32'(vecs[i].etr));
      check($sformatf("v%0d_b_tready", i), 32'(if_b.t_0_ready), 32'(vecs[i].etr));
      if (vecs[i].ev) begin
        check($sformatf("v%0d_a_data", i), 32'(if_a.i_0_data), 32'(vecs[i].eda));
        check($sformatf("v%0d_b_data", i), 32'(if_b.i_0_data), 32'(vecs[i].edb));
      end
    end

    // Reset in the middle of a word, then a fresh word must come out clean.
    @(posedge clk);
    #1;
    if_a.t_0_valid = 1'b1;
    if_a.t_0_data  = 32'hDDCCBBAA;
    if_a.i_0_ready = 1'b1;
    @(posedge clk);
    #1;
    if_a.t_0_valid = 1'b0;
    if_a.t_0_data  = 32'd0;
    #3;
    check("mid_beat0_a", 32'(if_a.i_0_data), 32'h000000AA);
    @(posedge clk);
    #4;
    check("mid_beat1_a", 32'(if_a.i_0_data), 32'h000000BB);
    check("mid_beat1_b", 32'(if_b.i_0_data), 32'h000000CC);
    reset = 1'b1;
    #1;
    check_idle("mid_rst");
    @(posedge clk);
    #1;
    reset = 1'b0;
    if_a.t_0_valid = 1'b1;
    if_a.t_0_data  = 32'h44332211;
    @(posedge clk);
    #1;
    if_a.t_0_valid = 1'b0;
    if_a.t_0_data  = 32'd0;
    for (int c = 0; c < 8; c++) begin
      #3;
      if (if_a.i_0_valid) qa.push_back({if_a.i_0_last, if_a.i_0_data});
      if (if_b.i_0_valid) qb.push_back({if_b.i_0_last, if_b.i_0_data});
      @(posedge clk);
      #1;
    end
    check("mid_count_a", 32'(qa.size()), 32'd4);
    check("mid_count_b", 32'(qb.size()), 32'd4);
    for (int k = 0; k < 4; k++) begin
      ea = {(k == 3), 8'(8'h11 * (k + 1))};
      eb = {(k == 3), 8'(8'h11 * (4 - k))};
      if (k < qa.size()) check($sformatf("mid_a_beat%0d", k), 32'(qa[k]), 32'(ea));
      if (k < qb.size()) check($sformatf("mid_b_beat%0d", k), 32'(qb[k]), 32'(eb));
    end

    // Randomized traffic: 50% valid, 50% ready; garbage data while valid is low.
    sent_c   = 0;
    sent_d   = 0;
    took_c   = 1'b0;
    took_d   = 1'b0;
    cyc      = 0;
    run_rand = 1'b1;
    while (!(sent_c == NW && sent_d == NW && sb_c.size() == 0 && sb_d.size() == 0) && cyc < 60000) begin
      @(posedge clk);
      #1;
      rc = $urandom();
      rd = $urandom();
      if (!if_c.t_0_valid || took_c) begin
        if_c.t_0_valid = (sent_c < NW) && rc[0];
        if_c.t_0_data  = rd[23:0];
      end
      if_c.i_0_ready = rc[1];
      if (!if_d.t_0_valid || took_d) begin
        if_d.t_0_valid = (sent_d < NW) && rc[2];
        if_d.t_0_data  = rd[31:24];
      end
      if_d.i_0_ready = rc[3];
      #3;
      took_c = if_c.t_0_valid && if_c.t_0_ready;
      took_d = if_d.t_0_valid && if_d.t_0_ready;
      if (took_c) sent_c++;
      if (took_d) sent_d++;
      cyc++;
    end
    @(posedge clk);
    #1;
    run_rand       = 1'b0;
    if_c.t_0_valid = 1'b0;
    if_d.t_0_valid = 1'b0;
    if (cyc >= 60000) fail_now("rand_timeout");
    check("c_words_sent", 32'(sent_c), 32'(NW));
    check("d_words_sent", 32'(sent_d), 32'(NW));
    check("c_beats_out", 32'(pops_c), 32'(3 * NW));
    check("d_beats_out", 32'(pops_d), 32'(NW));
    check("c_sb_left", 32'(sb_c.size()), 32'd0);
    check("d_sb_left", 32'(sb_d.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
